// File: rtl/sqrt_share_pkg.sv
// sqrt_share_pkg: shared defaults and tag type for the shared square-root front end.
// Optional statistics counters in the top are enabled by defining SQRT_SHARE_STATS_EN.
package sqrt_share_pkg;
   localparam int NUM_REQ_DEF  = 4;
   localparam int IN_W_DEF     = 23;
   localparam int OUT_W_DEF    = 24;
   localparam int SQRT_LAT_DEF = 1;

   // Tag id is sized for the largest supported requester count (8).
   localparam int TAG_ID_W = 3;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   // Increment with wrap at n.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction
endpackage

// File: rtl/sqrt_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Scans the eligibility vector starting at
// the pointer (wrapping) and returns a one-hot grant plus its index.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_elig,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   // First eligible index at or after the pointer wins.
   always_comb begin
      int j;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(i_ptr) + k) % N;
         if (!o_any && i_elig[j]) begin
            o_any    = 1'b1;
            o_gnt[j] = 1'b1;
            o_idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/sqrt_share_arbiter.sv
// sqrt_share_arbiter: shares one fixed-latency sqrt datapath between NUM_REQ requesters.
// Round-robin issue (one per cycle), a tag pipeline that remembers the owner of each
// in-flight op, and per-requester result registers released by rsp_ack.
// Define SQRT_SHARE_STATS_EN to add the stat_ops / stat_stall counters.
module sqrt_share_arbiter
   import sqrt_share_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int IN_W     = IN_W_DEF,
   parameter int OUT_W    = OUT_W_DEF,
   parameter int SQRT_LAT = SQRT_LAT_DEF
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0][IN_W-1:0]    req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [NUM_REQ-1:0][OUT_W-1:0]   rsp_data,
   input  logic [NUM_REQ-1:0]              rsp_ack,
   output logic [IN_W-1:0]                 sqrt_y,
   input  logic [OUT_W-1:0]                sqrt_result,
   output logic                            busy
`ifdef SQRT_SHARE_STATS_EN
   ,
   output logic [31:0]                     stat_ops,
   output logic [31:0]                     stat_stall
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic                          r_run;
   logic [IDX_W-1:0]              r_ptr;
   logic [NUM_REQ-1:0]            r_pending;
   logic [NUM_REQ-1:0]            r_rsp_valid;
   logic [NUM_REQ-1:0][OUT_W-1:0] r_rsp_data;
   logic [IN_W-1:0]               r_sqrt_y;
   // Stage 0 is loaded on the issue edge; stage SQRT_LAT lines up with a valid result.
   tag_t [SQRT_LAT:0]             r_tag;

   logic [NUM_REQ-1:0]            w_elig;
   logic [NUM_REQ-1:0]            w_gnt;
   logic [NUM_REQ-1:0]            w_ready;
   logic [NUM_REQ-1:0]            w_ack_clr;
   logic [IDX_W-1:0]              w_idx;
   logic                          w_any;
   logic                          w_hs;
   tag_t                          w_last;
   logic [IDX_W-1:0]              w_last_id;
   logic                          w_unused_id;

   assign w_elig = req_valid & ~r_pending;

   rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
      .i_elig (w_elig),
      .i_ptr  (r_ptr),
      .o_gnt  (w_gnt),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   // No grants until the first edge after reset release.
   assign w_ready     = w_gnt & {NUM_REQ{r_run}};
   assign w_hs        = w_any & r_run;
   assign w_ack_clr   = rsp_ack & r_rsp_valid;
   assign w_last      = r_tag[SQRT_LAT];
   assign w_last_id   = w_last.id[IDX_W-1:0];
   assign w_unused_id = ^w_last.id;

   assign req_ready = w_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign sqrt_y    = r_sqrt_y;
   assign busy      = |r_pending;

   // Issue side: operand register, round-robin pointer and run flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run    <= 1'b0;
         r_ptr    <= '0;
         r_sqrt_y <= '0;
      end else begin
         r_run <= 1'b1;
         if (w_hs) begin
            r_sqrt_y <= req_data[w_idx];
            r_ptr    <= IDX_W'(wrap_inc(int'(w_idx), NUM_REQ));
         end
      end
   end

   // Tag pipeline: shifts every cycle, bubble when no issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag <= '0;
      end else begin
         r_tag[0].valid <= w_hs;
         r_tag[0].id    <= TAG_ID_W'(w_idx);
         for (int s = 1; s <= SQRT_LAT; s++) r_tag[s] <= r_tag[s-1];
      end
   end

   // Outstanding tracking and result capture; ack frees both the register and the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending   <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_pending   <= (r_pending | w_ready) & ~w_ack_clr;
         r_rsp_valid <= r_rsp_valid & ~w_ack_clr;
         if (w_last.valid) begin
            r_rsp_valid[w_last_id] <= 1'b1;
            r_rsp_data[w_last_id]  <= sqrt_result;
         end
      end
   end

`ifdef SQRT_SHARE_STATS_EN
   logic [31:0] r_stat_ops;
   logic [31:0] r_stat_stall;

   assign stat_ops   = r_stat_ops;
   assign stat_stall = r_stat_stall;

   // Completed ops and cycles where some valid requester was left waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_ops   <= '0;
         r_stat_stall <= '0;
      end else begin
         if (w_last.valid) r_stat_ops <= r_stat_ops + 32'd1;
         if (|(req_valid & ~w_ready)) r_stat_stall <= r_stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// tb_sqrt_share_arbiter: randomized scoreboard bench with a stub sqrt ({1'b0,Y}, one stage).
module tb_sqrt_share_arbiter;
   localparam int N   = 4;
   localparam int IW  = 23;
   localparam int OW  = 24;
   localparam int LAT = 1;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [N-1:0]          req_valid = '0;
   logic [N-1:0][IW-1:0]  req_data = '0;
   logic [N-1:0]          req_ready;
   logic [N-1:0]          rsp_valid;
   logic [N-1:0][OW-1:0]  rsp_data;
   logic [N-1:0]          rsp_ack = '0;
   logic [IW-1:0]         sqrt_y;
   logic [OW-1:0]         sqrt_result;
   logic                  busy;
   logic [OW-1:0]         stub_q;
`ifdef SQRT_SHARE_STATS_EN
   logic [31:0]           stat_ops;
   logic [31:0]           stat_stall;
`endif

   sqrt_share_arbiter #(.NUM_REQ(N), .IN_W(IW), .OUT_W(OW), .SQRT_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
      .sqrt_y(sqrt_y), .sqrt_result(sqrt_result), .busy(busy)
`ifdef SQRT_SHARE_STATS_EN
      , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
   );

   always #5 clk = ~clk;

   // Stub sqrt unit: result is {0,Y} one edge after Y changes.
   always @(posedge clk) stub_q <= {1'b0, sqrt_y};
   assign sqrt_result = stub_q;

   // ---------------- reference model (owned by the stimulus process) ----------------
   typedef struct { int id; int due; } sched_t;
   sched_t         sched[$];
   logic [OW-1:0]  exp_q[N][$];
   bit             m_run;
   int             m_ptr;
   bit [N-1:0]     m_pend;
   bit [N-1:0]     m_rv;
   logic [IW-1:0]  m_y;
   int             kstep;

   // Snapshot of what the outputs must show during the current cycle.
   logic [N-1:0]   e_ready = '0;
   logic [N-1:0]   e_rv = '0;
   logic           e_busy = 1'b0;
   logic [IW-1:0]  e_y = '0;
   bit             e_rst = 1'b1;
   bit             started = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, kstep);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v);
      if (!m_run) return -1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (v[j] && !m_pend[j]) return j;
      end
      return -1;
   endfunction

   // Drive one cycle of inputs, publish expectations, then advance the model past the next edge.
   task automatic step(input logic r, input logic [N-1:0] v,
                       input logic [N-1:0][IW-1:0] d, input logic [N-1:0] a);
      int g;
      @(posedge clk); #1;
      rst_n = r; req_valid = v; req_data = d; rsp_ack = a;
      if (!r) begin
         m_run = 0; m_ptr = 0; m_pend = '0; m_rv = '0; m_y = '0;
         sched.delete();
         for (int i = 0; i < N; i++) exp_q[i].delete();
         e_ready = '0; e_rv = '0; e_busy = 1'b0; e_y = '0; e_rst = 1;
      end else begin
         e_rst = 0;
         g = pick(v);
         e_ready = (g >= 0) ? N'(1 << g) : '0;
         e_rv = m_rv; e_busy = |m_pend; e_y = m_y;
         for (int i = 0; i < N; i++)
            if (a[i] && m_rv[i]) begin m_rv[i] = 0; m_pend[i] = 0; end
         while (sched.size() > 0 && sched[0].due == kstep) begin
            m_rv[sched[0].id] = 1;
            void'(sched.pop_front());
         end
         if (g >= 0) begin
            m_pend[g] = 1;
            m_ptr = (g + 1) % N;
            m_y = d[g];
            exp_q[g].push_back({1'b0, d[g]});
            sched.push_back('{id: g, due: kstep + LAT + 1});
         end
         m_run = 1;
      end
      kstep++;
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      logic [N-1:0]  prev;
      logic [OW-1:0] held[N];
      prev = '0;
      for (int i = 0; i < N; i++) held[i] = '0;
      forever begin
         @(negedge clk);
         if (!started) continue;
         chk("req_ready", 64'(req_ready), 64'(e_ready));
         chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
         chk("busy", 64'(busy), 64'(e_busy));
         chk("sqrt_y", 64'(sqrt_y), 64'(e_y));
         if (e_rst) begin
            chk("reset_rsp_data", 64'(rsp_data), 64'd0);
            prev = '0;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (rsp_valid[i] && !prev[i]) begin
                  if (exp_q[i].size() == 0) begin
                     n_chk++; n_fail++;
                     $display("FAIL rsp_unexpected: requester %0d got %0h expected none", i, rsp_data[i]);
                  end else begin
                     held[i] = exp_q[i].pop_front();
                     chk("rsp_data", 64'(rsp_data[i]), 64'(held[i]));
                  end
               end else if (rsp_valid[i]) begin
                  chk("rsp_hold", 64'(rsp_data[i]), 64'(held[i]));
               end
            end
            prev = rsp_valid;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [N-1:0][IW-1:0] d;
      logic [N-1:0][IW-1:0] dz;
      dz = '0;
      kstep = 0;
      step(0, '0, dz, '0);
      step(0, '0, dz, '0);
      started = 1;
      step(0, '0, dz, '0);
      step(1, '0, dz, '0);

      // Single request on requester 2, held result, late ack.
      d = dz; d[2] = 23'h400000;
      step(1, 4'b0100, d, '0);
      repeat (4) step(1, '0, d, '0);
      step(1, '0, d, 4'b0100);
      repeat (2) step(1, '0, d, '0);

      // All four from reset: grants 0,1,2,3 on consecutive cycles, data i+1.
      step(0, '0, dz, '0);
      step(1, '0, dz, '0);
      for (int i = 0; i < N; i++) d[i] = IW'(i + 1);
      repeat (6) step(1, 4'hf, d, '0);
      step(1, '0, d, 4'hf);
      repeat (2) step(1, '0, d, '0);

      // Fairness between 0 and 3 with immediate acks.
      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < N; i++) d[i] = IW'($urandom);
         step(1, 4'b1001, d, rsp_valid & 4'b1001);
      end

      // Requester 1 never acks; others keep flowing, then release it.
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < N; i++) d[i] = IW'($urandom);
         step(1, 4'hf, d, rsp_valid & 4'b1101);
      end
      step(1, 4'hf, d, rsp_valid);
      repeat (4) step(1, 4'hf, d, rsp_valid);

      // Reset right after a handshake: nothing may come back.
      repeat (3) step(1, '0, d, 4'hf);
      d[0] = 23'h123456;
      step(1, 4'b0001, d, '0);
      step(0, '0, dz, '0);
      step(1, '0, dz, '0);
      repeat (5) step(1, '0, dz, '0);

      // Random traffic with occasional reset.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) d[i] = IW'($urandom);
         step(($urandom_range(0, 99) != 0), N'($urandom), d, N'($urandom));
      end

      // Drain and confirm every issued op came back.
      repeat (10) step(1, '0, dz, 4'hf);
      for (int i = 0; i < N; i++) chk("drain_q", 64'(exp_q[i].size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
